// File: rtl/rcv_deser.sv
// Asynchronous serial receive deserialiser: start/data/[parity]/stop framing,
// one-entry holding register with valid/ready handshake, and error pulses.
module rcv_deser #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rx_meta_p0;
    logic              rx_s;
    logic              rx_prev;
    logic [CNT_W-1:0]  baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bad;
    logic              start_det;
    logic              half_hit;
    logic              full_hit;
    logic              sample;
    logic              shift_en;
    logic              par_en;
    logic              stop_en;
    logic              vld_p1;
    logic              stop_p1;

    function automatic logic parity_bad(input logic [DATA_W-1:0] word, input logic bit_in);
        return (^word ^ bit_in) != 1'(PARITY_ODD);
    endfunction

    // Stage p0: two-flop synchroniser plus edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
        end else begin
            rx_meta_p0 <= rx_in;
            rx_s       <= rx_meta_p0;
            rx_prev    <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_det) state_nxt = START;
            START:   if (half_hit) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (full_hit && bit_cnt == DATA_LAST)
                         state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (full_hit) state_nxt = STOP;
            STOP:    if (full_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_det = 1'b0;
        sample    = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop_en   = 1'b0;
        half_hit  = (baud_cnt == HALF_LAST);
        full_hit  = (baud_cnt == FULL_LAST);
        case (state)
            IDLE:    start_det = rx_prev & ~rx_s;
            START:   sample = half_hit;
            DATA:    begin sample = full_hit; shift_en = full_hit; end
            PARITY:  begin sample = full_hit; par_en   = full_hit; end
            STOP:    begin sample = full_hit; stop_en  = full_hit; end
            default: sample = 1'b0;
        endcase
    end

    // The baud counter restarts at every sample, so the start-bit half-period
    // offset carries through to centre every later bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (state == IDLE || sample) baud_cnt <= '0;
            else                         baud_cnt <= baud_cnt + CNT_W'(1);
            if (state != DATA)           bit_cnt  <= '0;
            else if (shift_en)           bit_cnt  <= bit_cnt + BIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) shreg <= {rx_s, shreg[DATA_W-1:1]};
        if (stop_en)  stop_p1 <= rx_s;
    end

    // Stage p1: frame complete, stop bit and parity verdict held for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= stop_en;
            if (state == START) par_bad <= 1'b0;
            else if (par_en)    par_bad <= parity_bad(shreg, rx_s);
        end
    end

    // Stage p2: holding register, handshake and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            if (data_valid && data_ready) data_valid <= 1'b0;
            if (vld_p1) begin
                if (!stop_p1)                     frame_err  <= 1'b1;
                else if (par_bad)                 parity_err <= 1'b1;
                else if (!data_valid || data_ready) begin
                    data_out   <= shreg;
                    data_valid <= 1'b1;
                end else                          overrun    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rcv_deser.sv
// Directed bench for rcv_deser: an 8N1 instance and an 8E1 instance driven
// with hand-built frames, 16 clocks per bit.
module tb_rcv_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, rx_b;
    logic       ready_a, ready_b;
    logic [7:0] dout_a, dout_b;
    logic       dv_a, dv_b;
    logic       fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int rise_cyc_a = 0;
    int n_ld_a = 0, n_fe_a = 0, n_pe_a = 0, n_ov_a = 0;
    int n_ld_b = 0, n_fe_b = 0, n_pe_b = 0, n_ov_b = 0;
    logic dv_a_q = 1'b0, dv_b_q = 1'b0;

    rcv_deser #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .rx_in(rx_a), .data_out(dout_a), .data_valid(dv_a),
        .data_ready(ready_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

    rcv_deser #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst(rst), .rx_in(rx_b), .data_out(dout_b), .data_valid(dv_b),
        .data_ready(ready_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled mid-cycle; each high cycle of a pulse counts once.
    always @(negedge clk) begin
        if (fe_a === 1'b1) n_fe_a++;
        if (pe_a === 1'b1) n_pe_a++;
        if (ov_a === 1'b1) n_ov_a++;
        if (fe_b === 1'b1) n_fe_b++;
        if (pe_b === 1'b1) n_pe_b++;
        if (ov_b === 1'b1) n_ov_b++;
        if (dv_a === 1'b1 && dv_a_q !== 1'b1) begin n_ld_a++; rise_cyc_a = cyc; end
        if (dv_b === 1'b1 && dv_b_q !== 1'b1) n_ld_b++;
        dv_a_q = dv_a;
        dv_b_q = dv_b;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic send_frame(input bit sel, input logic [15:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (sel) rx_b = frame[i];
            else     rx_a = frame[i];
            if (i == 0) fall_cyc = cyc;
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (dout_a !== 8'h00) $display("FAIL rst_dout_a: got %h expected 00", dout_a); else n_pass++;
        n_checks++; if (dv_a !== 1'b0) $display("FAIL rst_valid_a: got %b expected 0", dv_a); else n_pass++;
        n_checks++; if (fe_a !== 1'b0) $display("FAIL rst_frame_err_a: got %b expected 0", fe_a); else n_pass++;
        n_checks++; if (pe_a !== 1'b0) $display("FAIL rst_parity_err_a: got %b expected 0", pe_a); else n_pass++;
        n_checks++; if (ov_a !== 1'b0) $display("FAIL rst_overrun_a: got %b expected 0", ov_a); else n_pass++;
        n_checks++; if (dout_b !== 8'h00) $display("FAIL rst_dout_b: got %h expected 00", dout_b); else n_pass++;
        n_checks++; if ({dv_b, fe_b, pe_b, ov_b} !== 4'b0000) $display("FAIL rst_outs_b: got %b expected 0000", {dv_b, fe_b, pe_b, ov_b}); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_ld_a = 0; n_fe_a = 0; n_pe_a = 0; n_ov_a = 0;
        n_ld_b = 0; n_fe_b = 0; n_pe_b = 0; n_ov_b = 0;
    endtask

    task automatic test_frame_a5();
        bit ok = 1'b0;
        int ld0 = n_ld_a;
        send_frame(1'b0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        for (int i = 0; i < 64 && !ok; i++) begin
            if (dv_a === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (ok !== 1'b1) $display("FAIL a5_valid: got %b expected 1", dv_a); else n_pass++;
        n_checks++; if (dout_a !== 8'hA5) $display("FAIL a5_data: got %h expected a5", dout_a); else n_pass++;
        n_checks++; if (rise_cyc_a - (fall_cyc + 1) !== 155) $display("FAIL a5_latency: got %0d expected 155", rise_cyc_a - (fall_cyc + 1)); else n_pass++;
        n_checks++; if ((n_ld_a - ld0) !== 1 || n_fe_a !== 0) $display("FAIL a5_events: got loads %0d ferr %0d expected 1 0", n_ld_a - ld0, n_fe_a); else n_pass++;
    endtask

    task automatic test_accept_a(input string name);
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        n_checks++; if (dv_a !== 1'b0) $display("FAIL %s: got valid %b expected 0", name, dv_a); else n_pass++;
    endtask

    task automatic test_glitch();
        int ld0 = n_ld_a;
        int err0 = n_fe_a + n_pe_a + n_ov_a;
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++; if (n_ld_a !== ld0) $display("FAIL glitch_loads: got %0d expected %0d", n_ld_a, ld0); else n_pass++;
        n_checks++; if ((n_fe_a + n_pe_a + n_ov_a) !== err0) $display("FAIL glitch_errors: got %0d expected %0d", n_fe_a + n_pe_a + n_ov_a, err0); else n_pass++;
        n_checks++; if (dv_a !== 1'b0) $display("FAIL glitch_valid: got %b expected 0", dv_a); else n_pass++;
    endtask

    task automatic test_frame_err();
        int ld0 = n_ld_a;
        int fe0 = n_fe_a;
        int pe0 = n_pe_a;
        send_frame(1'b0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10);
        rx_a = 1'b1;
        repeat (16) @(negedge clk);
        n_checks++; if (n_fe_a - fe0 !== 1) $display("FAIL ferr_pulse: got %0d cycles expected 1", n_fe_a - fe0); else n_pass++;
        n_checks++; if (n_ld_a !== ld0) $display("FAIL ferr_loads: got %0d expected %0d", n_ld_a, ld0); else n_pass++;
        n_checks++; if (dv_a !== 1'b0) $display("FAIL ferr_valid: got %b expected 0", dv_a); else n_pass++;
        n_checks++; if (n_pe_a !== pe0) $display("FAIL ferr_parity: got %0d expected %0d", n_pe_a, pe0); else n_pass++;
    endtask

    task automatic test_parity();
        int ld0 = n_ld_b;
        int pe0 = n_pe_b;
        bit ok = 1'b0;
        send_frame(1'b1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (4) @(negedge clk);
        n_checks++; if (n_pe_b - pe0 !== 1) $display("FAIL par_bad_pulse: got %0d expected 1", n_pe_b - pe0); else n_pass++;
        n_checks++; if (n_ld_b !== ld0 || dv_b !== 1'b0) $display("FAIL par_bad_valid: got loads %0d valid %b expected %0d 0", n_ld_b, dv_b, ld0); else n_pass++;
        n_checks++; if (n_fe_b !== 0) $display("FAIL par_bad_ferr: got %0d expected 0", n_fe_b); else n_pass++;
        send_frame(1'b1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        for (int i = 0; i < 64 && !ok; i++) begin
            if (dv_b === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (ok !== 1'b1) $display("FAIL par_good_valid: got %b expected 1", dv_b); else n_pass++;
        n_checks++; if (dout_b !== 8'h07) $display("FAIL par_good_data: got %h expected 07", dout_b); else n_pass++;
        n_checks++; if (n_pe_b - pe0 !== 1) $display("FAIL par_good_no_err: got %0d expected 1", n_pe_b - pe0); else n_pass++;
    endtask

    task automatic test_back_to_back_overrun();
        int ld0 = n_ld_a;
        int ov0 = n_ov_a;
        ready_a = 1'b0;
        send_frame(1'b0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
        send_frame(1'b0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
        repeat (4) @(negedge clk);
        n_checks++; if (n_ov_a - ov0 !== 1) $display("FAIL ovr_pulse: got %0d expected 1", n_ov_a - ov0); else n_pass++;
        n_checks++; if (dv_a !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", dv_a); else n_pass++;
        n_checks++; if (dout_a !== 8'h11) $display("FAIL ovr_data: got %h expected 11", dout_a); else n_pass++;
        n_checks++; if (n_ld_a - ld0 !== 1) $display("FAIL ovr_loads: got %0d expected 1", n_ld_a - ld0); else n_pass++;
        test_accept_a("ovr_accept");
    endtask

    task automatic test_mid_reset();
        logic [15:0] frame = {6'b0, 1'b1, 8'h55, 1'b0};
        int ld0 = n_ld_a;
        int err0 = n_fe_a + n_pe_a + n_ov_a;
        bit ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_a = frame[i];
            repeat (16) @(negedge clk);
        end
        rst = 1'b1; rx_a = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        n_checks++; if (n_ld_a !== ld0 || dv_a !== 1'b0) $display("FAIL midrst_valid: got loads %0d valid %b expected %0d 0", n_ld_a, dv_a, ld0); else n_pass++;
        n_checks++; if ((n_fe_a + n_pe_a + n_ov_a) !== err0) $display("FAIL midrst_errors: got %0d expected %0d", n_fe_a + n_pe_a + n_ov_a, err0); else n_pass++;
        send_frame(1'b0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        for (int i = 0; i < 64 && !ok; i++) begin
            if (dv_a === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (ok !== 1'b1) $display("FAIL recover_valid: got %b expected 1", dv_a); else n_pass++;
        n_checks++; if (dout_a !== 8'h5A) $display("FAIL recover_data: got %h expected 5a", dout_a); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        @(negedge clk);
        test_reset();
        test_frame_a5();
        test_accept_a("a5_accept");
        test_glitch();
        test_frame_err();
        test_parity();
        test_back_to_back_overrun();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
